// File: rtl/uart_cmd_responder.sv
// UART command responder: parses W/R frames, drives the register bus, replies one byte.
// Optional inter-byte frame timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_responder #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_wait,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    READ,
    CAPT,
    SEND
  } state_t;

  state_t state;
  state_t state_n;
  logic   op_w;
  logic   is_cmd;
  logic   drop_st;
  logic   to_hit;

  assign is_cmd  = (rx_data == OP_W) || (rx_data == OP_R);
  assign drop_st = (state == EXEC) || (state == READ) ||
                   (state == CAPT) || (state == SEND);

  assign tx_we  = (state == SEND);
  assign reg_we = (state == EXEC);
  assign reg_re = (state == READ);
  assign busy   = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (rx_valid) state_n = is_cmd ? GET_ADDR : SEND;
      GET_ADDR:
        if (rx_valid)    state_n = op_w ? GET_DATA : READ;
        else if (to_hit) state_n = IDLE;
      GET_DATA:
        if (rx_valid)    state_n = EXEC;
        else if (to_hit) state_n = IDLE;
      EXEC: state_n = SEND;
      READ: state_n = CAPT;
      CAPT: state_n = SEND;
      SEND:
        if (!tx_wait) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      op_w      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_data   <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && rx_valid) begin
        op_w <= (rx_data == OP_W);
        if (!is_cmd) tx_data <= RSP_Q;
      end
      if (state == GET_ADDR && rx_valid)
        reg_addr <= rx_data[ADDR_W-1:0];
      if (state == GET_DATA && rx_valid)
        reg_wdata <= rx_data;
      if (state == EXEC) tx_data <= RSP_K;
      if (state == CAPT) tx_data <= reg_rdata;
      // Bytes arriving while a command is in flight are lost.
      if (rx_valid && drop_st) overrun <= 1'b1;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          in_frame;

  assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
  assign to_hit   = in_frame && !rx_valid &&
                    (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (!in_frame || rx_valid || to_hit) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign to_hit     = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: write, read, bad opcode,
// back-pressure with overrun, mid-frame reset and optional timeout.
module tb_uart_cmd_responder;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int AW = 4;
  localparam int TO = 100;
`else
  localparam int AW = 8;
  localparam int TO = 250000;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_we;
  logic          tx_wait = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata = 8'h00;
  logic          busy;
  logic          overrun;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  int we_cnt = 0;
  int re_cnt = 0;
  int tx_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;
  logic [AW-1:0] we_addr;
  logic [7:0]    we_data;
  logic [AW-1:0] re_addr;
  logic [7:0]    last_tx;

  uart_cmd_responder #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_we(tx_we),
    .tx_wait(tx_wait),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .busy(busy),
    .overrun(overrun),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (reg_re) begin
      re_cnt++;
      re_addr = reg_addr;
    end
    if (reg_we && reg_re) both_cnt++;
    if (tx_we && !tx_wait) begin
      tx_cnt++;
      last_tx = tx_data;
    end
    if (timeout) to_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int base, input string nm);
    int n = 0;
    while (tx_cnt == base && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (tx_cnt == base) begin
      errors++;
      $display("FAIL %s_reply_timeout got no reply want 1", nm);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(3);
    checks++;
    if ({tx_we, busy, reg_we, reg_re, overrun, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000000",
               {tx_we, busy, reg_we, reg_re, overrun, timeout});
    end
    checks++;
    if ({tx_data, reg_wdata} !== 16'h0000 || reg_addr !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0 0 0",
               tx_data, reg_wdata, reg_addr);
    end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_write;
    int w0 = we_cnt;
    int r0 = re_cnt;
    int t0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h05);
    send_byte(8'hA5);
    checks++;
    if (reg_we !== 1'b1 || reg_addr !== AW'(8'h05) || reg_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_strobe got we=%b a=%h d=%h want 1 05 a5",
               reg_we, reg_addr, reg_wdata);
    end
    wait_tx(t0, "wr");
    checks++;
    if (last_tx !== 8'h4B) begin
      errors++;
      $display("FAIL wr_reply got %h want 4b", last_tx);
    end
    tick(10);
    checks++;
    if (we_cnt - w0 != 1 || re_cnt - r0 != 0 || tx_cnt - t0 != 1) begin
      errors++;
      $display("FAIL wr_counts got we=%0d re=%0d tx=%0d want 1 0 1",
               we_cnt - w0, re_cnt - r0, tx_cnt - t0);
    end
    checks++;
    if (we_addr !== AW'(8'h05) || we_data !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_bus got a=%h d=%h busy=%b want 05 a5 0",
               we_addr, we_data, busy);
    end
  endtask

  task automatic test_read(input logic [7:0] a, input logic [7:0] rd);
    int w0 = we_cnt;
    int r0 = re_cnt;
    int t0 = tx_cnt;
    reg_rdata = rd;
    send_byte(8'h52);
    send_byte(a);
    checks++;
    if (reg_re !== 1'b1 || reg_we !== 1'b0 || reg_addr !== AW'(a)) begin
      errors++;
      $display("FAIL rd_strobe got re=%b we=%b a=%h want 1 0 %h",
               reg_re, reg_we, reg_addr, AW'(a));
    end
    tick(1);
    checks++;
    if (reg_re !== 1'b0 || tx_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_capt got re=%b tx_we=%b want 0 0", reg_re, tx_we);
    end
    tick(1);
    checks++;
    if (tx_we !== 1'b1 || tx_data !== rd) begin
      errors++;
      $display("FAIL rd_send got tx_we=%b d=%h want 1 %h", tx_we, tx_data, rd);
    end
    wait_tx(t0, "rd");
    tick(5);
    checks++;
    if (re_cnt - r0 != 1 || we_cnt - w0 != 0 || tx_cnt - t0 != 1 ||
        re_addr !== AW'(a) || last_tx !== rd) begin
      errors++;
      $display("FAIL rd_counts got re=%0d we=%0d tx=%0d a=%h d=%h want 1 0 1 %h %h",
               re_cnt - r0, we_cnt - w0, tx_cnt - t0, re_addr, last_tx, AW'(a), rd);
    end
  endtask

  task automatic test_bad_opcode;
    int w0 = we_cnt;
    int r0 = re_cnt;
    int t0 = tx_cnt;
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b1 || tx_we !== 1'b1 || tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL bad_send got busy=%b tx_we=%b d=%h want 1 1 3f",
               busy, tx_we, tx_data);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || tx_we !== 1'b0) begin
      errors++;
      $display("FAIL bad_idle got busy=%b tx_we=%b want 0 0", busy, tx_we);
    end
    checks++;
    if (we_cnt != w0 || re_cnt != r0 || tx_cnt - t0 != 1) begin
      errors++;
      $display("FAIL bad_counts got we=%0d re=%0d tx=%0d want 0 0 1",
               we_cnt - w0, re_cnt - r0, tx_cnt - t0);
    end
  endtask

  task automatic test_overrun;
    int t0 = tx_cnt;
    int unstable = 0;
    int n = 0;
    tx_wait = 1'b1;
    reg_rdata = 8'h77;
    send_byte(8'h52);
    send_byte(8'h09);
    while (!tx_we && n < 20) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        rx_data  = 8'h57;
        rx_valid = 1'b1;
      end
      tick(1);
      rx_valid = 1'b0;
      if (tx_we !== 1'b1 || tx_data !== 8'h77) unstable++;
    end
    checks++;
    if (unstable != 0 || tx_cnt != t0) begin
      errors++;
      $display("FAIL ovr_hold got unstable=%0d tx=%0d want 0 0",
               unstable, tx_cnt - t0);
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag got ovr=%b busy=%b want 1 1", overrun, busy);
    end
    tx_wait = 1'b0;
    wait_tx(t0, "ovr");
    tick(10);
    checks++;
    if (tx_cnt - t0 != 1 || last_tx !== 8'h77 || busy !== 1'b0 ||
        overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after got tx=%0d d=%h busy=%b ovr=%b want 1 77 0 1",
               tx_cnt - t0, last_tx, busy, overrun);
    end
  endtask

  task automatic test_reset_midframe;
    int w0 = we_cnt;
    int t0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h05);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got busy=%b want 1", busy);
    end
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || tx_we !== 1'b0 ||
        reg_addr !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid got busy=%b ovr=%b tx_we=%b a=%h d=%h want 0 0 0 0 0",
               busy, overrun, tx_we, reg_addr, tx_data);
    end
    tick(10);
    checks++;
    if (we_cnt != w0 || tx_cnt != t0) begin
      errors++;
      $display("FAIL rst_quiet got we=%0d tx=%0d want 0 0",
               we_cnt - w0, tx_cnt - t0);
    end
    test_read(8'h05, 8'hC3);
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout;
    int w0 = we_cnt;
    int t0 = tx_cnt;
    int o0 = to_cnt;
    int n = 0;
    send_byte(8'h57);
    tick(50);
    checks++;
    if (busy !== 1'b1 || to_cnt != o0) begin
      errors++;
      $display("FAIL to_early got busy=%b to=%0d want 1 0", busy, to_cnt - o0);
    end
    while (to_cnt == o0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(5);
    checks++;
    if (to_cnt - o0 != 1 || busy !== 1'b0 || tx_cnt != t0 || we_cnt != w0) begin
      errors++;
      $display("FAIL to_abort got to=%0d busy=%b tx=%0d we=%0d want 1 0 0 0",
               to_cnt - o0, busy, tx_cnt - t0, we_cnt - w0);
    end
    t0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'hF3);
    send_byte(8'h11);
    checks++;
    if (reg_we !== 1'b1 || reg_addr !== 4'h3 || reg_wdata !== 8'h11) begin
      errors++;
      $display("FAIL to_trunc got we=%b a=%h d=%h want 1 3 11",
               reg_we, reg_addr, reg_wdata);
    end
    wait_tx(t0, "trunc");
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read(8'h05, 8'h3C);
    test_bad_opcode;
    test_overrun;
    test_reset_midframe;
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL we_re_overlap got %0d want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
